// File: rtl/segment_pkg.sv
// Shared 7-segment definitions used by the display driver and the
// capture path: glyph patterns, digit slot indices and FSM states.
package segment_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int LOW_ONES  = 0;
  localparam int LOW_TENS  = 1;
  localparam int HIGH_ONES = 2;
  localparam int HIGH_TENS = 3;

  typedef enum logic {
    COLLECT,
    COMMIT
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder; any pattern that is
// not one of the ten glyphs is flagged invalid.
module seg7_decode
  import segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    bcd     = 4'd0;
    invalid = 1'b0;
    unique case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// Watches a scanned 4-digit 7-segment bus, captures each settled digit
// and rebuilds the two 6-bit values shown by the driver.
module segment_capture
  import segment_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bytee,
  input  logic [6:0]  segment,
  output logic [11:0] data_show,
  output logic        data_valid,
  output logic        decode_error
);

  localparam logic [3:0] CAP_AT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] sel_q;
  logic [6:0] seg_q;
  logic       sel_new;
  logic [3:0] cnt;
  logic [3:0] bcd [4];
  logic [3:0] inv;
  logic [3:0] flags;
  state_t     state, state_nx;

  logic       one_hot, hold, capture, illegal, commit, reject;
  logic [3:0] dec_bcd;
  logic       dec_inv;
  logic [6:0] hi_val, lo_val;

  seg7_decode u_dec (
    .pattern (seg_q),
    .bcd     (dec_bcd),
    .invalid (dec_inv)
  );

  // hold: the select about to be registered equals the current one
  assign one_hot = $onehot(sel_q);
  assign hold    = (bytee == sel_q);
  assign capture = one_hot && hold && (cnt == CAP_AT);
  assign illegal = sel_new && !one_hot && (sel_q != 4'd0);

  assign hi_val = 7'(bcd[HIGH_TENS]) * 7'd10 + 7'(bcd[HIGH_ONES]);
  assign lo_val = 7'(bcd[LOW_TENS]) * 7'd10 + 7'(bcd[LOW_ONES]);
  assign reject = (|inv) || (hi_val > 7'd63) || (lo_val > 7'd63);

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      COLLECT: if (&flags) state_nx = COMMIT;
      COMMIT: begin
        commit   = 1'b1;
        state_nx = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      seg_q   <= '0;
      sel_new <= 1'b0;
      cnt     <= '0;
    end else begin
      sel_q   <= bytee;
      seg_q   <= segment;
      sel_new <= !hold;
      if (!hold || !one_hot) cnt <= '0;
      else if (cnt != 4'hF)  cnt <= cnt + 4'd1;
    end
  end

  // Flags clear on commit; a capture on that same edge survives the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
      flags <= '0;
      inv   <= '0;
      for (int i = 0; i < 4; i++) bcd[i] <= '0;
    end else begin
      state <= state_nx;
      flags <= (commit ? 4'd0 : flags) | (capture ? sel_q : 4'd0);
      for (int i = 0; i < 4; i++) begin
        if (capture && sel_q[i]) begin
          bcd[i] <= dec_bcd;
          inv[i] <= dec_inv;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_show    <= '0;
      data_valid   <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      data_valid   <= commit && !reject;
      decode_error <= (commit && reject) || illegal;
      if (commit && !reject) data_show <= {hi_val[5:0], lo_val[5:0]};
    end
  end

endmodule

// File: tb/tb_segment_capture.sv
// Self-checking bench for segment_capture: table of scanned frames plus
// hand-written corner sequences, checked by a pulse scoreboard.
module tb_segment_capture;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bytee;
  logic [6:0]  segment;
  logic [11:0] data_show;
  logic        data_valid;
  logic        decode_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0][6:0] pats;
    logic            err;
    logic [11:0]     data;
  } vec_t;

  typedef struct {
    logic        err;
    int          cyc;
    logic [11:0] data;
  } exp_t;

  exp_t q[$];
  vec_t vecs [11];

  segment_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock        (clk),
    .reset        (reset),
    .bytee        (bytee),
    .segment      (segment),
    .data_show    (data_show),
    .data_valid   (data_valid),
    .decode_error (decode_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid || decode_error) begin
        checks++;
        if (data_valid && decode_error) begin
          failures++;
          $display("FAIL both_pulses cyc=%0d", cyc);
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d valid=%0b err=%0b",
                   cyc, data_valid, decode_error);
        end else begin
          exp_t e;
          e = q.pop_front();
          checks++;
          if (decode_error !== e.err || cyc != e.cyc) begin
            failures++;
            $display("FAIL pulse_kind got err=%0b cyc=%0d want err=%0b cyc=%0d",
                     decode_error, cyc, e.err, e.cyc);
          end
          checks++;
          if (data_show !== e.data) begin
            failures++;
            $display("FAIL pulse_data got %h want %h", data_show, e.data);
          end
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse cyc=%0d want_cyc=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic scan_digit(input int d, input logic [6:0] pat,
                            input int dwell);
    bytee   = 4'(1 << d);
    segment = pat;
    repeat (dwell) @(negedge clk);
    bytee   = 4'd0;
    segment = 7'd0;
    @(negedge clk);
  endtask

  // Scans high tens first, low ones last; expectation pushed before the
  // last digit so the scoreboard has it before the pulse can appear
  task automatic scan_frame(input logic [3:0][6:0] pats, input logic err,
                            input logic [11:0] data);
    exp_t e;
    for (int d = 3; d >= 1; d--) scan_digit(d, pats[d], 4);
    e.err  = err;
    e.cyc  = cyc + 1 + SETTLE + 2;
    e.data = data;
    q.push_back(e);
    scan_digit(0, pats[0], 4);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{pats: {7'h06, 7'h5B, 7'h4F, 7'h66}, err: 1'b0, data: 12'h322};
    vecs[1]  = '{pats: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, err: 1'b0, data: 12'h000};
    vecs[2]  = '{pats: {7'h7D, 7'h4F, 7'h7D, 7'h4F}, err: 1'b0, data: 12'hFFF};
    vecs[3]  = '{pats: {7'h7D, 7'h66, 7'h3F, 7'h3F}, err: 1'b1, data: 12'hFFF};
    vecs[4]  = '{pats: {7'h3F, 7'h3F, 7'h7D, 7'h66}, err: 1'b1, data: 12'hFFF};
    vecs[5]  = '{pats: {7'h3F, 7'h6F, 7'h6D, 7'h7F}, err: 1'b0, data: 12'h27A};
    vecs[6]  = '{pats: {7'h06, 7'h5B, 7'h4F, 7'h66}, err: 1'b0, data: 12'h322};
    vecs[7]  = '{pats: {7'h00, 7'h5B, 7'h4F, 7'h66}, err: 1'b1, data: 12'h322};
    vecs[8]  = '{pats: {7'h07, 7'h3F, 7'h3F, 7'h3F}, err: 1'b1, data: 12'h322};
    vecs[9]  = '{pats: {7'h6F, 7'h6F, 7'h6F, 7'h6F}, err: 1'b1, data: 12'h322};
    vecs[10] = '{pats: {7'h06, 7'h5B, 7'h08, 7'h66}, err: 1'b1, data: 12'h322};

    reset   = 1'b1;
    bytee   = 4'($urandom);
    segment = 7'($urandom);
    repeat (3) begin
      @(negedge clk);
      bytee   = 4'($urandom);
      segment = 7'($urandom);
    end
    check("reset_data", 32'(data_show), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_err", 32'(decode_error), 32'h0);
    bytee   = 4'd0;
    segment = 7'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_data", 32'(data_show), 32'h0);

    foreach (vecs[i]) begin
      scan_frame(vecs[i].pats, vecs[i].err, vecs[i].data);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_hold", i), 32'(data_show), 32'(vecs[i].data));
    end

    // Short dwell on low ones: no commit until it is rescanned properly
    scan_digit(3, 7'h06, 4);
    scan_digit(2, 7'h5B, 4);
    scan_digit(1, 7'h4F, 4);
    scan_digit(0, 7'h66, 1);
    repeat (20) @(negedge clk);
    check("short_dwell_hold", 32'(data_show), 32'h322);
    e.err  = 1'b0;
    e.cyc  = cyc + 1 + SETTLE + 2;
    e.data = 12'h323;
    q.push_back(e);
    scan_digit(0, 7'h6D, 4);
    repeat (6) @(negedge clk);
    check("short_dwell_rescan", 32'(data_show), 32'h323);

    // Illegal select: error one edge after it is registered, no capture
    e.err  = 1'b1;
    e.cyc  = cyc + 2;
    e.data = 12'h323;
    q.push_back(e);
    bytee   = 4'b0011;
    segment = 7'h3F;
    repeat (3) @(negedge clk);
    bytee   = 4'd0;
    segment = 7'd0;
    repeat (10) @(negedge clk);
    check("illegal_hold", 32'(data_show), 32'h323);
    scan_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0, 12'h322);
    repeat (4) @(negedge clk);

    // Reset mid-frame: stale low-digit flags would commit early
    scan_digit(0, 7'h6F, 4);
    scan_digit(1, 7'h6F, 4);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_data", 32'(data_show), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    scan_frame({7'h3F, 7'h6D, 7'h6D, 7'h6F}, 1'b0, 12'h17B);
    repeat (20) @(negedge clk);
    check("final_data", 32'(data_show), 32'h17B);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_capture.md
# segment_capture

Receive-side companion to the multiplexed 7-segment display driver. It watches the scanned digit-enable and segment lines, decodes each stable digit back to BCD, and reassembles the two 6-bit values, high and low, into the same 12-bit `data_show` word that fed the driver. It sits in loopback and self-check paths and on the display-monitor input. It flags corrupt frames instead of passing them on.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: number of consecutive cycles a digit select must be held before it is sampled; legal range 1–15.

Ports:
- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `bytee`  in  4: one-hot digit enable. Bit 0 = low ones, bit 1 = low tens, bit 2 = high ones, bit 3 = high tens. 4'b0000 = blanking.
- `segment`  in  7: segment pattern, bit order gfedcba, active-high.
- `data_show`  out  12: last good frame. [11:6] = high value, [5:0] = low value.
- `data_valid`  out  1: one-cycle pulse when `data_show` updates.
- `decode_error`  out  1: one-cycle pulse on a rejected frame or an illegal select.

## Operation
- **Input register:** `bytee` and `segment` are registered once, into `sel_q` and `seg_q`. All decisions use the registered values.
- **Settle counter:** 4-bit, saturating.
  - Cleared whenever `sel_q` changes.
  - Increments while `sel_q` is one-hot and unchanged.
- **Capture:** when the counter reaches `SETTLE_CYCLES`, that digit is captured exactly once per dwell. The capture writes the decoded BCD and an invalid flag into the digit slot and sets the slot's captured flag.
- **Recapture:** a second capture of the same digit before the frame completes overwrites the slot; latest wins.
- **Decode table:** 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other pattern marks the digit invalid.
- **Blanking:** `sel_q`=0000 is legal. It resets the settle counter and sets no error.
- **Illegal select:** `sel_q` with two or more bits set resets the settle counter and pulses `decode_error` for one cycle. No slot is written.
- **FSM states:**
  - COLLECT: waiting for all four captured flags.
  - COMMIT: one cycle; evaluates the frame and clears all flags.
  - Transitions: COLLECT→COMMIT on the edge after the fourth distinct flag sets; COMMIT→COLLECT unconditionally.
- **Frame arithmetic:** value = tens×10 + ones, computed 7 bits wide per half.
  - Frame rejected if any slot is invalid or either value is greater than 63.
  - Good frame: `data_show` loads, and `data_valid` pulses.
  - Rejected frame: `data_show` holds, and `decode_error` pulses.
- **Capture during COMMIT:** a capture landing in the COMMIT cycle counts toward the next frame; its flag is set after the clear.

## Timing
- **Reset values:** `data_show`=0, `data_valid`=0, `decode_error`=0. `sel_q`/`seg_q`=0, settle counter=0, all flags clear, FSM=COLLECT.
- **Asynchronous reset mid-frame:** partial captures are discarded.
- **Capture latency:** a select first present at the inputs before edge t is captured at edge t+`SETTLE_CYCLES`.
- **Short dwell:** a select held for fewer than `SETTLE_CYCLES` cycles is never captured.
- **Output latency:** `data_show`/`data_valid` update 2 edges after the fourth capture (COLLECT→COMMIT, then output register). `data_valid` and `decode_error` are never high together from the same frame.
- **Illegal-select error:** `decode_error` for an illegal select is asserted 1 edge after the select is registered.
- **Simultaneous errors:** if an illegal select and a rejected COMMIT occur on the same cycle, a single pulse is output.

## Structure
- **Package `segment_pkg`:**
  - The ten 7-bit pattern constants.
  - Digit-index constants: LOW_ONES=0, LOW_TENS=1, HIGH_ONES=2, HIGH_TENS=3.
  - FSM state typedef.
  - The driver shares this package.
- **Sub-module `seg7_decode`:** combinational; pattern in → 4-bit BCD plus invalid flag out. Instantiated once on `seg_q`.

## Test plan
- **Reset and idle:** assert `reset` with random inputs, then release with `bytee`=0000 → all outputs 0, no pulses for 100 cycles.
- **Clean frame "12:34":** scan with `SETTLE_CYCLES`=2 and dwell 4 cycles per digit, blanking between digits → `data_show`=12'h322 (12:34), exactly one `data_valid` pulse per frame, 2 edges after the fourth capture.
- **Short dwell:** one digit held for 1 cycle, others normal → no frame commits until that digit is rescanned with a full dwell.
- **Illegal select:** `bytee`=0011 for 3 cycles → `decode_error` pulse, no capture, `data_show` unchanged.
- **Corrupt frame:** pattern 0x00 on high tens, or high value "70" (tens 0x07, ones 0x3F) → `decode_error` pulse, `data_valid` stays 0, `data_show` keeps 12'h322.
- **Reset mid-frame:** reset after two captures, then a full "05:59" scan → `data_show`=12'h17B (05:59); no stale digits appear in the result.
